// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, instruction field positions and immediate formats for the decode stage
package decode_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_W    = 3;
    localparam int IMM_RAW_W = 7;

    localparam int OPC_LSB  = 0;
    localparam int RD_LSB   = 3;
    localparam int RS1_LSB  = 6;
    localparam int RS2_LSB  = 9;
    localparam int FUNC_LSB = 12;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ITYPE = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_BEQ   = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b101;
    localparam logic [2:0] OP_BLT   = 3'b110;
    localparam logic [2:0] OP_JR    = 3'b111;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [2:0] op);
        case (op)
            OP_ITYPE, OP_LOAD:                 return IMM_I;
            OP_STORE, OP_BEQ, OP_BNE, OP_BLT:  return IMM_S;
            default:                           return IMM_NONE;
        endcase
    endfunction

    // Raw 7-bit immediate before sign extension to the datapath width.
    function automatic logic [IMM_RAW_W-1:0] imm_raw(input logic [15:0] ir, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return ir[15:9];
            IMM_S:   return {ir[15:12], ir[5:3]};
            default: return '0;
        endcase
    endfunction

    // rs1 is read by every opcode; rs2 only by these.
    function automatic logic reads_rs2(input logic [2:0] op);
        case (op)
            OP_RTYPE, OP_STORE, OP_BEQ, OP_BNE, OP_BLT: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 8-entry register file, two read ports, one write port with same-cycle bypass
module decode_regfile
    import decode_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int NREGS = NUM_REGS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] raddr1,
    output logic [XLEN-1:0]  rdata1,
    input  logic [REG_W-1:0] raddr2,
    output logic [XLEN-1:0]  rdata2,
    input  logic             wen,
    input  logic [REG_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next register contents; r0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (wen && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: r0 reads zero, a write in flight to the same register is bypassed.
    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (wen && (waddr == raddr1)) rdata1 = wdata;
        if (wen && (waddr == raddr2)) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end

endmodule

// File: rtl/pipelined_decode.sv
// rtl/pipelined_decode.sv - IF/ID and ID/EX pipeline registers with decode, forwarding, hazards and branch resolve
module pipelined_decode
    import decode_pkg::*;
#(
    parameter int              XLEN     = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] pc_in,
    input  logic [15:0]     ir_in,
    output logic            stall_out,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            wb_en,
    input  logic [2:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_fwd_valid,
    input  logic [2:0]      ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_fwd_valid,
    input  logic [2:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            ex_load_pending,
    input  logic [2:0]      ex_load_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_arg1,
    output logic [XLEN-1:0] out_arg2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_rs1,
    output logic [2:0]      out_rs2,
    output logic [2:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_alu_src,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [2:0]      out_alu_op
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] arg1;
        logic [XLEN-1:0] arg2;
        logic [XLEN-1:0] imm;
        logic [2:0]      rs1;
        logic [2:0]      rs2;
        logic [2:0]      rd;
        logic            reg_write;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      alu_op;
    } idex_t;

    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [15:0]     ifid_ir_q, ifid_ir_d;
    idex_t           idex_q, idex_d, idex_rst, dec;

    logic [2:0]      opcode, rs1, rs2, rd;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2, arg1, arg2, imm;
    logic            load_use, bp_stall, stall, taken;

    // Priority: r0, EX result, MEM result, then regfile (which already bypasses WB).
    function automatic logic [XLEN-1:0] resolve_src(
        input logic [2:0] rs, input logic [XLEN-1:0] rf_val,
        input logic exv, input logic [2:0] exrd, input logic [XLEN-1:0] exd,
        input logic mv, input logic [2:0] mrd, input logic [XLEN-1:0] md);
        if (rs == 3'd0)              return '0;
        else if (exv && exrd == rs)  return exd;
        else if (mv && mrd == rs)    return md;
        else                         return rf_val;
    endfunction

    decode_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2),
        .rdata2 (rf_rdata2),
        .wen    (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    // Field extraction, immediate generation and operand resolution for the IF/ID instruction.
    always_comb begin
        logic [IMM_RAW_W-1:0] raw;
        opcode = ifid_ir_q[OPC_LSB +: 3];
        rd     = ifid_ir_q[RD_LSB +: 3];
        rs1    = ifid_ir_q[RS1_LSB +: 3];
        rs2    = ifid_ir_q[RS2_LSB +: 3];
        raw    = imm_raw(ifid_ir_q, imm_fmt(opcode));
        imm    = {{(XLEN-IMM_RAW_W){raw[IMM_RAW_W-1]}}, raw};
        arg1   = resolve_src(rs1, rf_rdata1, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                             mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
        arg2   = resolve_src(rs2, rf_rdata2, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                             mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
    end

    // Control decode packed into the ID/EX record format.
    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.pc        = ifid_pc_q;
        dec.arg1      = arg1;
        dec.arg2      = arg2;
        dec.imm       = imm;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.rd        = rd;
        dec.reg_write = (opcode == OP_RTYPE) || (opcode == OP_ITYPE) || (opcode == OP_LOAD);
        dec.alu_src   = (opcode == OP_ITYPE) || (opcode == OP_LOAD) || (opcode == OP_STORE);
        dec.mem_read  = (opcode == OP_LOAD);
        dec.mem_write = (opcode == OP_STORE);
        dec.alu_op    = (opcode == OP_RTYPE) ? ifid_ir_q[FUNC_LSB +: 3] : 3'b000;
    end

    // Hazard detection, branch evaluation and redirect.
    always_comb begin
        load_use = ifid_valid_q && ex_load_pending && (ex_load_rd != 3'd0) &&
                   ((ex_load_rd == rs1) || (reads_rs2(opcode) && (ex_load_rd == rs2)));
        bp_stall = idex_q.valid && !out_ready;
        stall    = load_use || bp_stall;
        case (opcode)
            OP_BEQ:  taken = (arg1 == arg2);
            OP_BNE:  taken = (arg1 != arg2);
            OP_BLT:  taken = ($signed(arg1) < $signed(arg2));
            OP_JR:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
        redirect_valid = ifid_valid_q && !stall && taken;
        redirect_pc    = (opcode == OP_JR) ? arg1 : (ifid_pc_q + imm);
        stall_out      = stall;
    end

    // IF/ID next state: squash on redirect, hold on stall, otherwise take the fetch.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_ir_d    = ifid_ir_q;
        if (redirect_valid) begin
            ifid_valid_d = 1'b0;
            ifid_ir_d    = '0;
        end else if (!stall) begin
            ifid_valid_d = in_valid;
            ifid_pc_d    = pc_in;
            ifid_ir_d    = ir_in;
        end
    end

    // ID/EX next state: hold under backpressure, bubble on load-use or empty IF/ID.
    always_comb begin
        idex_rst    = '0;
        idex_rst.pc = RESET_PC;
        idex_d      = idex_q;
        if (!bp_stall) begin
            if (load_use || !ifid_valid_q) begin
                idex_d = '0;
            end else begin
                idex_d = dec;
            end
        end
    end

    // Pipeline registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= RESET_PC;
            ifid_ir_q    <= '0;
            idex_q       <= idex_rst;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_ir_q    <= ifid_ir_d;
            idex_q       <= idex_d;
        end
    end

    assign out_valid     = idex_q.valid;
    assign out_pc        = idex_q.pc;
    assign out_arg1      = idex_q.arg1;
    assign out_arg2      = idex_q.arg2;
    assign out_imm       = idex_q.imm;
    assign out_rs1       = idex_q.rs1;
    assign out_rs2       = idex_q.rs2;
    assign out_rd        = idex_q.rd;
    assign out_reg_write = idex_q.reg_write;
    assign out_alu_src   = idex_q.alu_src;
    assign out_mem_read  = idex_q.mem_read;
    assign out_mem_write = idex_q.mem_write;
    assign out_alu_op    = idex_q.alu_op;

endmodule

// File: tb/tb_pipelined_decode.sv
// tb/tb_pipelined_decode.sv - table and scoreboard bench for pipelined_decode
module tb_pipelined_decode;

    localparam int          XLEN = 16;
    localparam logic [15:0] RPC  = 16'h0040;

    logic        clk = 1'b0;
    logic        reset, in_valid, wb_en, ex_fwd_valid, mem_fwd_valid, ex_load_pending, out_ready;
    logic [15:0] pc_in, ir_in, wb_data, ex_fwd_data, mem_fwd_data;
    logic [2:0]  wb_rd, ex_fwd_rd, mem_fwd_rd, ex_load_rd;
    logic        stall_out, redirect_valid, out_valid;
    logic [15:0] redirect_pc, out_pc, out_arg1, out_arg2, out_imm;
    logic [2:0]  out_rs1, out_rs2, out_rd, out_alu_op;
    logic        out_reg_write, out_alu_src, out_mem_read, out_mem_write;

    pipelined_decode #(.XLEN(XLEN), .RESET_PC(RPC), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in), .ir_in(ir_in),
        .stall_out(stall_out), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .ex_load_pending(ex_load_pending), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_arg1(out_arg1), .out_arg2(out_arg2), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_alu_src(out_alu_src),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_alu_op(out_alu_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc, arg1, arg2, imm;
        logic [2:0]  rs1, rs2, rd;
        logic        rw, as, mr, mw;
        logic [2:0]  alu;
    } exp_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [3:0] func);
        return {func, rs2, rs1, rd, op};
    endfunction

    function automatic exp_t mk(input logic [15:0] pc, a1, a2, imm, input logic [2:0] rs1, rs2, rd,
                                input logic rw, as, mr, mw, input logic [2:0] alu);
        exp_t e;
        e.pc = pc; e.arg1 = a1; e.arg2 = a2; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.rw = rw; e.as = as; e.mr = mr; e.mw = mw; e.alu = alu;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.pc = out_pc; a.arg1 = out_arg1; a.arg2 = out_arg2; a.imm = out_imm;
        a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd;
        a.rw = out_reg_write; a.as = out_alu_src; a.mr = out_mem_read; a.mw = out_mem_write;
        a.alu = out_alu_op;
        return a;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // One clock: sample stall/hold before the edge, then score any new ID/EX content.
    task automatic tick(output logic st);
        logic hold;
        exp_t e;
        #1;
        hold = (out_valid === 1'b1) && (out_ready === 1'b0);
        st   = (stall_out === 1'b1);
        @(posedge clk);
        #1;
        if (out_valid === 1'b1 && !hold) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected got=%h want=none", actual());
            end else begin
                e = sb_q.pop_front();
                chk("sb_out", actual(), e);
            end
        end
    endtask

    task automatic step();
        logic st;
        tick(st);
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] ir);
        logic st;
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        pc_in    = pc;
        ir_in    = ir;
        for (int n = 0; n < 20 && !acc; n++) begin
            tick(st);
            if (!st) acc = 1'b1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout got=stalled want=accepted pc=%h", pc);
        end
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] rd, input logic [15:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        step();
        wb_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; pc_in = '0; ir_in = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
        mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
        ex_load_pending = 1'b0; ex_load_rd = '0; out_ready = 1'b1;

        vecs[0] = '{16'h0020, enc(0,5,1,2,4'd3),  mk(16'h0020,16'h0005,16'h0100,16'h0000,1,2,5,1,0,0,0,3)};
        vecs[1] = '{16'h0022, enc(1,6,3,7,4'd15), mk(16'h0022,16'hFFFE,16'h0000,16'hFFFF,3,7,6,1,1,0,0,0)};
        vecs[2] = '{16'h0024, enc(2,7,4,1,4'd3),  mk(16'h0024,16'h7FFF,16'h0005,16'h0019,4,1,7,1,1,1,0,0)};
        vecs[3] = '{16'h0026, enc(3,5,2,1,4'd10), mk(16'h0026,16'h0100,16'h0005,16'hFFD5,2,1,5,0,1,0,1,0)};
        vecs[4] = '{16'h0028, enc(4,0,1,2,4'd0),  mk(16'h0028,16'h0005,16'h0100,16'h0000,1,2,0,0,0,0,0,0)};
        vecs[5] = '{16'h002A, enc(6,0,1,3,4'd0),  mk(16'h002A,16'h0005,16'hFFFE,16'h0000,1,3,0,0,0,0,0,0)};
        vecs[6] = '{16'h002C, enc(5,0,1,1,4'd0),  mk(16'h002C,16'h0005,16'h0005,16'h0000,1,1,0,0,0,0,0,0)};
        vecs[7] = '{16'h002E, enc(0,0,0,4,4'd14), mk(16'h002E,16'h0000,16'h7FFF,16'h0000,0,4,0,1,0,0,0,6)};

        // reset state and first cycle after release
        step(); step();
        reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, RPC);
        chk("rst_reg_write", out_reg_write, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_redirect", redirect_valid, 0);

        // WB bypass: r1 written while ADD r2,r1,r1 sits in IF/ID
        sb_q.push_back(mk(16'h0000,16'h0005,16'h0005,16'h0000,1,1,2,1,0,0,0,0));
        fetch(16'h0000, enc(0,2,1,1,4'd0));
        wb_en = 1'b1; wb_rd = 3'd1; wb_data = 16'h0005;
        step();
        wb_en = 1'b0;
        wb_write(3'd2, 16'h0100);
        wb_write(3'd3, 16'hFFFE);
        wb_write(3'd4, 16'h7FFF);

        // table: decode of every format, non-taken branches (BLT signed boundary)
        foreach (vecs[i]) begin
            sb_q.push_back(vecs[i].e);
            fetch(vecs[i].pc, vecs[i].ir);
            #1;
            chk("tbl_redirect", redirect_valid, 0);
        end
        step(); step();

        // load-use on r3: one stall cycle, bubble, then issue with MEM-forwarded data
        sb_q.push_back(mk(16'h0030,16'h0033,16'h0005,16'h0000,3,1,5,1,0,0,0,0));
        fetch(16'h0030, enc(0,5,3,1,4'd0));
        ex_load_pending = 1'b1; ex_load_rd = 3'd3;
        #1;
        chk("lu_stall", stall_out, 1);
        step();
        chk("lu_bubble", out_valid, 0);
        ex_load_pending = 1'b0;
        mem_fwd_valid = 1'b1; mem_fwd_rd = 3'd3; mem_fwd_data = 16'h0033;
        #1;
        chk("lu_release", stall_out, 0);
        step();
        mem_fwd_valid = 1'b0;
        step();
        // I-type does not read rs2, so a pending load on its rs2 field is no hazard
        sb_q.push_back(mk(16'h0034,16'h0005,16'hFFFE,16'h0003,1,3,6,1,1,0,0,0));
        fetch(16'h0034, enc(1,6,1,3,4'd0));
        ex_load_pending = 1'b1; ex_load_rd = 3'd3;
        #1;
        chk("lu_rs2_unused", stall_out, 0);
        step();
        ex_load_pending = 1'b0;
        step();

        // BEQ taken via EX forward, wrong-path fetch squashed
        sb_q.push_back(mk(16'h0010,16'h0005,16'h0005,16'hFFFC,1,2,4,0,0,0,0,0));
        fetch(16'h0010, enc(4,4,1,2,4'd15));
        ex_fwd_valid = 1'b1; ex_fwd_rd = 3'd2; ex_fwd_data = 16'h0005;
        in_valid = 1'b1; pc_in = 16'h0012; ir_in = enc(0,7,1,1,4'd0);
        #1;
        chk("beq_redirect", redirect_valid, 1);
        chk("beq_target", redirect_pc, 16'h000C);
        step();
        in_valid = 1'b0; ex_fwd_valid = 1'b0;
        #1;
        chk("beq_squash_redirect", redirect_valid, 0);
        step();
        chk("beq_squash_bubble", out_valid, 0);
        step();

        // BLT taken (signed -2 < 5) and JR through register
        sb_q.push_back(mk(16'h0060,16'hFFFE,16'h0005,16'h0002,3,1,2,0,0,0,0,0));
        fetch(16'h0060, enc(6,2,3,1,4'd0));
        #1;
        chk("blt_redirect", redirect_valid, 1);
        chk("blt_target", redirect_pc, 16'h0062);
        step(); step();
        sb_q.push_back(mk(16'h0050,16'h0100,16'h0000,16'h0000,2,0,0,0,0,0,0,0));
        fetch(16'h0050, enc(7,0,2,0,4'd0));
        #1;
        chk("jr_redirect", redirect_valid, 1);
        chk("jr_target", redirect_pc, 16'h0100);
        step(); step();

        // backpressure for three cycles: outputs stable, nothing lost or duplicated
        sb_q.push_back(mk(16'h0070,16'h0005,16'h0100,16'h0000,1,2,5,1,0,0,0,1));
        sb_q.push_back(mk(16'h0072,16'h0100,16'h0000,16'h0000,2,0,6,1,1,0,0,0));
        sb_q.push_back(mk(16'h0074,16'h7FFF,16'h0000,16'h0008,4,0,7,1,1,1,0,0));
        fetch(16'h0070, enc(0,5,1,2,4'd1));
        fetch(16'h0072, enc(1,6,2,0,4'd0));
        out_ready = 1'b0;
        in_valid = 1'b1; pc_in = 16'h0074; ir_in = enc(2,7,4,0,4'd1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_stall", stall_out, 1);
            step();
            chk("bp_hold_pc", out_pc, 16'h0070);
            chk("bp_hold_arg2", out_arg2, 16'h0100);
        end
        out_ready = 1'b1;
        fetch(16'h0074, enc(2,7,4,0,4'd1));
        step(); step();

        // EX beats MEM for the same register; r0 ignores forwarding
        sb_q.push_back(mk(16'h0080,16'h1111,16'h1111,16'h0000,4,4,1,1,0,0,0,0));
        sb_q.push_back(mk(16'h0082,16'h0000,16'h2222,16'h0000,0,4,2,1,0,0,0,0));
        fetch(16'h0080, enc(0,1,4,4,4'd0));
        ex_fwd_valid = 1'b1; ex_fwd_rd = 3'd4; ex_fwd_data = 16'h1111;
        mem_fwd_valid = 1'b1; mem_fwd_rd = 3'd4; mem_fwd_data = 16'h2222;
        fetch(16'h0082, enc(0,2,0,4,4'd0));
        ex_fwd_rd = 3'd0; ex_fwd_data = 16'h3333;
        step();
        ex_fwd_valid = 1'b0; mem_fwd_valid = 1'b0;
        step();

        // reset during backpressure discards held work and clears registers
        sb_q.push_back(mk(16'h0090,16'h0005,16'h0005,16'h0000,1,1,3,1,0,0,0,0));
        fetch(16'h0090, enc(0,3,1,1,4'd0));
        fetch(16'h0092, enc(0,4,1,1,4'd0));
        out_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("rst_bp_out_valid", out_valid, 0);
        chk("rst_bp_out_pc", out_pc, RPC);
        chk("rst_bp_stall", stall_out, 0);
        reset = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_bp_redirect", redirect_valid, 0);
        step(); step();
        sb_q.push_back(mk(16'h00A0,16'h0000,16'h0000,16'h0000,1,4,5,1,0,0,0,0));
        fetch(16'h00A0, enc(0,5,1,4,4'd0));
        step(); step();

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
